// File: rtl/instr_issue_pkg.sv
// Shared definitions for the instruction issue stage: opcode constants,
// FSM state encoding and the opcode-class helper used by issue and decode.
package instr_issue_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned IMM_W = 27;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd2;
    localparam logic [OP_W-1:0] OP_AND  = 5'd3;
    localparam logic [OP_W-1:0] OP_OR   = 5'd4;
    localparam logic [OP_W-1:0] OP_LBD  = 5'd10;
    localparam logic [OP_W-1:0] OP_LDW  = 5'd11;
    localparam logic [OP_W-1:0] OP_STB  = 5'd12;
    localparam logic [OP_W-1:0] OP_STW  = 5'd13;
    localparam logic [OP_W-1:0] OP_MOV  = 5'd14;
    localparam logic [OP_W-1:0] OP_BEQ  = 5'd30;
    localparam logic [OP_W-1:0] OP_JUMP = 5'd31;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        ISSUE    = 2'd1,
        WAIT_MEM = 2'd2,
        HALT     = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_MEM     = 3'd1,
        CLS_BEQ     = 3'd2,
        CLS_JUMP    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_t;

    // Map an opcode onto its execution class
    function automatic op_class_t op_class(input logic [OP_W-1:0] opc);
        op_class_t cls;
        cls = CLS_ILLEGAL;
        case (opc)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_MOV: cls = CLS_R;
            OP_LBD, OP_LDW, OP_STB, OP_STW:                cls = CLS_MEM;
            OP_BEQ:                                        cls = CLS_BEQ;
            OP_JUMP:                                       cls = CLS_JUMP;
            default:                                       cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/instr_issue.sv
// Instruction fetch/issue sequencer: fetches one word, issues its opcode to
// the control decoder, waits on memory ops and updates the pc.
// Build option: ISSUE_ILLEGAL_TRAP_EN -- an illegal opcode halts the stage
// until reset instead of being retired as a NOP.
module instr_issue
    import instr_issue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  op,
    output logic        op_valid,
    input  logic        mem_done,
    input  logic        beq_taken,
    output logic [26:0] imm,
    output logic [31:0] pc,
    output logic        illegal
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_imem_req;
    logic        r_op_valid;
    logic        r_illegal;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_ir_nxt;
    logic        w_req_nxt;
    logic        w_valid_nxt;
    logic        w_illegal_nxt;
    op_class_t   w_issue_cls;
    op_class_t   w_nxt_cls;
    logic [31:0] w_pc_seq;
    logic [31:0] w_beq_off;
    logic [31:0] w_jump_pc;

    assign w_pc_seq  = r_pc + 32'd4;
    assign w_beq_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_jump_pc = {r_pc[31:29], r_ir[26:0], 2'b00};

    // State, instruction register, pc and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= 32'd0;
            r_imem_req <= 1'b0;
            r_op_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_imem_req <= w_req_nxt;
            r_op_valid <= w_valid_nxt;
            r_illegal  <= w_illegal_nxt;
        end
    end

    // Next-state, pc update and next-cycle output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_req_nxt     = 1'b0;
        w_valid_nxt   = 1'b0;
        w_illegal_nxt = 1'b0;
        w_issue_cls   = op_class(r_ir[31:27]);

        case (r_state)
            FETCH: begin
                // an ack only counts once our own request is visible
                if (r_imem_req && imem_ack) begin
                    w_ir_nxt    = imem_rdata;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = FETCH;
                case (w_issue_cls)
                    CLS_R:    w_pc_nxt = w_pc_seq;
                    CLS_MEM: begin
                        if (mem_done) begin
                            w_pc_nxt = w_pc_seq;
                        end else begin
                            w_state_nxt = WAIT_MEM;
                        end
                    end
                    CLS_BEQ:  w_pc_nxt = beq_taken ? (w_pc_seq + w_beq_off) : w_pc_seq;
                    CLS_JUMP: w_pc_nxt = w_jump_pc;
                    default: begin
`ifdef ISSUE_ILLEGAL_TRAP_EN
                        w_state_nxt = HALT;
`else
                        w_pc_nxt    = w_pc_seq;
`endif
                    end
                endcase
            end
            WAIT_MEM: begin
                if (mem_done) begin
                    w_pc_nxt    = w_pc_seq;
                    w_state_nxt = FETCH;
                end
            end
            HALT: w_state_nxt = HALT;
            default: w_state_nxt = FETCH;
        endcase

        w_nxt_cls     = op_class(w_ir_nxt[31:27]);
        w_req_nxt     = (w_state_nxt == FETCH);
        w_valid_nxt   = (w_state_nxt == WAIT_MEM) ||
                        ((w_state_nxt == ISSUE) && (w_nxt_cls != CLS_ILLEGAL));
        w_illegal_nxt = (w_state_nxt == ISSUE) && (w_nxt_cls == CLS_ILLEGAL);
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign op        = r_ir[31:27];
    assign imm       = r_ir[26:0];
    assign op_valid  = r_op_valid;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_instr_issue.sv
// Testbench for instr_issue: directed scenarios followed by random
// instruction streams, checked against a per-instruction pc model.
module tb_instr_issue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [4:0]  op;
    logic        op_valid;
    logic        mem_done;
    logic        beq_taken;
    logic [26:0] imm;
    logic [31:0] pc;
    logic        illegal;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_pc;
    bit          trap_en;

    instr_issue #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .op         (op),
        .op_valid   (op_valid),
        .mem_done   (mem_done),
        .beq_taken  (beq_taken),
        .imm        (imm),
        .pc         (pc),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int opc, input logic [26:0] im);
        logic [4:0] o;
        o = 5'(opc);
        return {o, im};
    endfunction

    function automatic bit is_legal(input int opc);
        return opc inside {[0:4], [10:14], 30, 31};
    endfunction

    function automatic bit is_mem(input int opc);
        return opc inside {[10:13]};
    endfunction

    // Architectural next pc for one retired instruction
    function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic [31:0] w, input bit taken);
        int opc;
        int off;
        logic [15:0] lo;
        opc = int'(w[31:27]);
        lo  = w[15:0];
        if (opc == 31) return {cur[31:29], w[26:0], 2'b00};
        if (opc == 30 && taken) begin
            off = int'($signed(lo)) * 4;
            return cur + 32'd4 + 32'(off);
        end
        return cur + 32'd4;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; imem_ack = 1'b0; mem_done = 1'b0; beq_taken = 1'b0;
        #1;
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, RESET_PC);
        @(negedge clk);
        @(negedge clk);
        check("rst_held_req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        m_pc = RESET_PC;
    endtask

    // Fetch, issue and retire one instruction, checking every visible step
    task automatic run_instr(input logic [31:0] w, input int ack_dly, input int mem_dly, input bit taken);
        int  opc;
        int  waited;
        int  vcnt;
        bit  legal;
        bit  mem;
        opc   = int'(w[31:27]);
        legal = is_legal(opc);
        mem   = is_mem(opc);
        waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("fetch_req", 32'(imem_req), 32'd1);
        if (imem_req !== 1'b1) return;
        check("imem_addr", imem_addr, m_pc);
        repeat (ack_dly) begin
            imem_rdata = $urandom; mem_done = 1'($urandom); beq_taken = 1'($urandom);
            @(negedge clk);
            check("req_held", 32'(imem_req), 32'd1);
            check("no_valid_in_fetch", 32'(op_valid), 32'd0);
        end
        imem_ack = 1'b1; imem_rdata = w; mem_done = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        check("issue_valid", 32'(op_valid), 32'(legal));
        check("issue_illegal", 32'(illegal), 32'(!legal));
        check("issue_op", 32'(op), 32'(w[31:27]));
        check("issue_imm", 32'(imm), 32'(w[26:0]));
        check("issue_no_req", 32'(imem_req), 32'd0);
        vcnt = op_valid ? 1 : 0;
        beq_taken = (opc == 30) ? taken : 1'($urandom);
        mem_done  = mem ? (mem_dly == 0) : 1'($urandom);
        if (mem) begin
            for (int k = 1; k <= mem_dly; k++) begin
                @(negedge clk);
                if (op_valid === 1'b1) vcnt++;
                check("wait_op", 32'(op), 32'(w[31:27]));
                mem_done  = (k == mem_dly);
                beq_taken = 1'($urandom);
            end
        end
        @(negedge clk);
        mem_done = 1'b0; beq_taken = 1'b0;
        if (mem) check("mem_valid_cycles", 32'(vcnt), 32'(mem_dly + 1));
        check("retire_valid", 32'(op_valid), 32'd0);
        check("retire_illegal", 32'(illegal), 32'd0);
        if (!legal && trap_en) begin
            repeat (5) begin
                check("halt_req", 32'(imem_req), 32'd0);
                check("halt_valid", 32'(op_valid), 32'd0);
                @(negedge clk);
            end
            return;
        end
        m_pc = model_next_pc(m_pc, w, taken);
        check("next_pc", pc, m_pc);
    endtask

    initial begin
        int legal_ops[12] = '{0, 1, 2, 3, 4, 10, 11, 12, 13, 14, 30, 31};
        logic [31:0] w;
        int opc;
`ifdef ISSUE_ILLEGAL_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        imem_rdata = 32'd0;
        @(negedge clk);
        do_reset();

        run_instr(32'h0000_0000, 1, 0, 1'b0);                       // ADD -> 4
        run_instr(mk(14, 27'($urandom)), 0, 0, 1'b0);                // MOV -> 8
        run_instr(mk(11, 27'($urandom)), 0, 3, 1'b0);                // LDW at 8 -> 12
        run_instr(mk(1, 27'($urandom)), 2, 0, 1'b0);                 // SUB -> 16
        run_instr(mk(30, {11'($urandom), 16'hFFFE}), 0, 0, 1'b1);    // BEQ taken -> 12
        run_instr(mk(2, 27'($urandom)), 0, 0, 1'b0);                 // MUL -> 16
        run_instr(mk(30, {11'($urandom), 16'hFFFE}), 0, 0, 1'b0);    // BEQ not taken -> 20
        run_instr(mk(30, {11'd0, 16'h8000}), 0, 0, 1'b1);            // wraps below zero
        run_instr(mk(31, 27'h0), 0, 0, 1'b0);                        // -> E000_0000
        run_instr(mk(31, 27'h000_0010), 0, 0, 1'b0);                 // -> E000_0040
        check("jump_e0000040", pc, 32'hE000_0040);
        run_instr(mk(31, 27'h7FF_FFFF), 0, 0, 1'b0);                 // -> FFFF_FFFC
        run_instr(mk(0, 27'($urandom)), 0, 0, 1'b0);                 // wraps to 0
        run_instr(mk(31, 27'h8), 0, 0, 1'b0);                        // -> 0x20
        run_instr(mk(5, 27'($urandom)), 0, 0, 1'b0);                 // illegal at 0x20
        if (!trap_en) check("illegal_nop_pc", pc, 32'h24);

        // Reset in the middle of a memory wait, with a stale ack around release
        do_reset();
        run_instr(mk(31, 27'h10), 0, 0, 1'b0);                       // -> 0x40
        while (imem_req !== 1'b1) @(negedge clk);
        check("mid_fetch_addr", imem_addr, 32'h40);
        imem_ack = 1'b1; imem_rdata = mk(11, 27'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        check("mid_wait_valid", 32'(op_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(op_valid), 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_pc", pc, RESET_PC);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = mk(0, 27'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("late_ack_ignored", 32'(op_valid), 32'd0);
        check("late_ack_no_illegal", 32'(illegal), 32'd0);
        check("restart_addr", imem_addr, RESET_PC);
        imem_ack = 1'b0;
        m_pc = RESET_PC;

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            if (trap_en) opc = legal_ops[$urandom_range(0, 11)];
            else         opc = int'($urandom_range(0, 31));
            w = mk(opc, 27'($urandom));
            run_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
